// File: rtl/linked_list_pkg.sv
// -----------------------------------------------------------------------------
// linked_list_pkg
//   Shared definitions for the linked-list data-table blocks.
//   - LL_TABLE_ADDR_WIDTH : address width of the linked-list data table.
//   - ll_empty_ptr_state_t: free-list manager states (initial fill / running).
// -----------------------------------------------------------------------------
package linked_list_pkg;

  localparam int LL_TABLE_ADDR_WIDTH = 8;

  typedef enum logic {
    INIT_S = 1'b0,
    RUN_S  = 1'b1
  } ll_empty_ptr_state_t;

endpackage : linked_list_pkg

// File: rtl/ll_empty_ptr_ram.sv
// -----------------------------------------------------------------------------
// ll_empty_ptr_ram
//   Simple dual-port RAM, 2**A_WIDTH x A_WIDTH, holding the free-address FIFO.
//   One write port and one read port with a registered (1-cycle) output.
//   The read data register only updates when a read is issued, so it holds
//   the last fetched word until the consumer takes it.
//
// Ports
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read strobe
//   rd_addr_i  : read address
//   rd_data_o  : registered read data (valid the cycle after rd_en_i)
// -----------------------------------------------------------------------------
module ll_empty_ptr_ram
  import linked_list_pkg::*;
#(
  parameter int A_WIDTH = LL_TABLE_ADDR_WIDTH
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [A_WIDTH-1:0] wr_addr_i,
  input  logic [A_WIDTH-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [A_WIDTH-1:0] rd_addr_i,
  output logic [A_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** A_WIDTH;

  logic [A_WIDTH-1:0] mem_q [DEPTH];
  logic [A_WIDTH-1:0] rd_data_q;

  // NOTE: the array and its read register have no reset so the array maps
  // onto block RAM; every entry is written by the init sweep before it can
  // be read, and the read register is only consumed after a read is issued.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : ll_empty_ptr_ram

// File: rtl/ll_empty_ptr_storage.sv
// -----------------------------------------------------------------------------
// ll_empty_ptr_storage
//   Free-list manager for the linked-list data table. After reset it sweeps
//   every table address into a RAM-backed FIFO, then presents the oldest free
//   address (show-ahead) to the insert engine and recycles addresses released
//   by the delete engine.
//
//   The head path is a two-slot pipeline in front of the RAM:
//     RAM read register (rdv_q)  ->  head register (val_q / head_q)
//   A read is issued whenever a committed, not-yet-fetched entry exists and
//   the RAM read register is free or draining into the head this cycle, which
//   sustains one pop per cycle.
//
// Ports
//   clk_i                   : clock
//   rst_n_i                 : asynchronous active-low reset
//   add_empty_ptr_i         : address being freed (delete stage)
//   add_empty_ptr_en_i      : one-cycle push strobe
//   next_empty_ptr_o        : oldest free address
//   next_empty_ptr_val_o    : next_empty_ptr_o is valid
//   next_empty_ptr_rd_ack_i : consumer takes next_empty_ptr_o (pop)
//   init_done_o             : initial fill complete
//   empty_cnt_o             : number of free addresses held
//   push_err_o              : one-cycle pulse, push dropped (full or init)
// -----------------------------------------------------------------------------
module ll_empty_ptr_storage
  import linked_list_pkg::*;
#(
  parameter int A_WIDTH = LL_TABLE_ADDR_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  input  logic               next_empty_ptr_rd_ack_i,
  output logic               init_done_o,
  output logic [A_WIDTH:0]   empty_cnt_o,
  output logic               push_err_o
);

  localparam int                 DEPTH     = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0]   DEPTH_CNT = (A_WIDTH + 1)'(DEPTH);
  localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ll_empty_ptr_state_t state_q, state_d;
  logic [A_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;   // doubles as the init counter
  logic [A_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;   // address of the head entry
  logic [A_WIDTH:0]    cnt_q, cnt_d;
  logic                rdv_q, rdv_d;         // RAM read register holds an entry
  logic                val_q, val_d;
  logic [A_WIDTH-1:0]  head_q, head_d;
  logic                init_done_q, init_done_d;
  logic                push_err_q, push_err_d;

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  logic               pop_acc;
  logic               push_acc;
  logic [A_WIDTH:0]   in_flight;
  logic [A_WIDTH:0]   unfetched;
  logic               head_load;
  logic               fetch;
  logic [A_WIDTH-1:0] rd_addr;
  logic               ram_wr_en;
  logic [A_WIDTH-1:0] ram_wr_data;
  logic [A_WIDTH-1:0] ram_rd_data;

  assign pop_acc  = next_empty_ptr_rd_ack_i && val_q;
  assign push_acc = add_empty_ptr_en_i && (state_q == RUN_S) &&
                    ((cnt_q != DEPTH_CNT) || pop_acc);

  // Entries already pulled out of the RAM into the head pipeline.
  assign in_flight = (A_WIDTH + 1)'(val_q) + (A_WIDTH + 1)'(rdv_q);

  // cnt_q only counts entries whose RAM write has completed, so anything it
  // counts beyond the pipeline is safe to read without a write-read bypass.
  assign unfetched = cnt_q - in_flight;

  assign head_load = rdv_q && (!val_q || pop_acc);
  assign fetch     = (state_q == RUN_S) && (unfetched != '0) &&
                     (!rdv_q || head_load);

  // Next unfetched entry sits just past whatever is already in the pipeline.
  assign rd_addr = rd_ptr_q + in_flight[A_WIDTH-1:0];

  // During the init sweep the RAM is loaded with its own address.
  assign ram_wr_en   = (state_q == INIT_S) || push_acc;
  assign ram_wr_data = (state_q == INIT_S) ? wr_ptr_q : add_empty_ptr_i;

  ll_empty_ptr_ram #(
    .A_WIDTH (A_WIDTH)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (ram_wr_data),
    .rd_en_i   (fetch),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rd_data)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets its default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rdv_d       = rdv_q;
    val_d       = val_q;
    head_d      = head_q;
    init_done_d = init_done_q;
    push_err_d  = add_empty_ptr_en_i && !push_acc;

    case (state_q)
      INIT_S: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (wr_ptr_q == LAST_ADDR) begin
          state_d     = RUN_S;
          init_done_d = 1'b1;
        end
      end

      RUN_S: begin
        if (push_acc) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + (A_WIDTH + 1)'(push_acc) - (A_WIDTH + 1)'(pop_acc);
      end

      default: begin
        state_d = INIT_S;
      end
    endcase

    // Head pipeline; idle during init because fetch is gated by RUN_S.
    if (head_load) begin
      head_d = ram_rd_data;
      val_d  = 1'b1;
    end else if (pop_acc) begin
      val_d  = 1'b0;
    end

    if (fetch) begin
      rdv_d = 1'b1;
    end else if (head_load) begin
      rdv_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= INIT_S;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rdv_q       <= 1'b0;
      val_q       <= 1'b0;
      head_q      <= '0;
      init_done_q <= 1'b0;
      push_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rdv_q       <= rdv_d;
      val_q       <= val_d;
      head_q      <= head_d;
      init_done_q <= init_done_d;
      push_err_q  <= push_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign next_empty_ptr_o     = head_q;
  assign next_empty_ptr_val_o = val_q;
  assign init_done_o          = init_done_q;
  assign empty_cnt_o          = cnt_q;
  assign push_err_o           = push_err_q;

endmodule : ll_empty_ptr_storage

// File: tb/tb_ll_empty_ptr_storage.sv
// -----------------------------------------------------------------------------
// tb_ll_empty_ptr_storage
//   Self-checking bench for ll_empty_ptr_storage with A_WIDTH=3. A reference
//   model keeps the free list as a queue of entries, each tagged with the
//   earliest clock edge at which it may be presented as head (two edges after
//   its push, or two edges after init completes for the swept addresses).
// -----------------------------------------------------------------------------
module tb_ll_empty_ptr_storage;

  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [AW-1:0] add_empty_ptr_i;
  logic          add_empty_ptr_en_i;
  logic [AW-1:0] next_empty_ptr_o;
  logic          next_empty_ptr_val_o;
  logic          next_empty_ptr_rd_ack_i;
  logic          init_done_o;
  logic [AW:0]   empty_cnt_o;
  logic          push_err_o;

  ll_empty_ptr_storage #(
    .A_WIDTH (AW)
  ) dut (
    .clk_i                   (clk_i),
    .rst_n_i                 (rst_n_i),
    .add_empty_ptr_i         (add_empty_ptr_i),
    .add_empty_ptr_en_i      (add_empty_ptr_en_i),
    .next_empty_ptr_o        (next_empty_ptr_o),
    .next_empty_ptr_val_o    (next_empty_ptr_val_o),
    .next_empty_ptr_rd_ack_i (next_empty_ptr_rd_ack_i),
    .init_done_o             (init_done_o),
    .empty_cnt_o             (empty_cnt_o),
    .push_err_o              (push_err_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0] addr;
    int            ready;   // first edge index at which it may be head
  } ent_t;

  ent_t q[$];
  int   n_edge;     // edges since reset release
  bit   m_run;
  int   m_init_k;
  bit   m_err;

  function automatic bit model_val();
    return (q.size() > 0) && (q[0].ready <= n_edge);
  endfunction

  function automatic void model_reset();
    q.delete();
    n_edge   = 0;
    m_run    = 1'b0;
    m_init_k = 0;
    m_err    = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input logic [AW-1:0] addr, input bit ack);
    bit   pop;
    bit   ok;
    ent_t e;
    pop = m_run && ack && model_val();
    n_edge++;
    if (!m_run) begin
      m_err = en;
      m_init_k++;
      if (m_init_k == DEPTH) begin
        m_run = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          e.addr  = AW'(i);
          e.ready = n_edge + 2;
          q.push_back(e);
        end
      end
    end else begin
      ok    = en && ((q.size() < DEPTH) || pop);
      m_err = en && !ok;
      if (pop) void'(q.pop_front());
      if (ok) begin
        e.addr  = addr;
        e.ready = n_edge + 2;
        q.push_back(e);
      end
    end
  endfunction

  function automatic int model_cnt();
    return m_run ? q.size() : m_init_k;
  endfunction

  task automatic check_outputs();
    check("val", 32'(next_empty_ptr_val_o), 32'(model_val()));
    if (model_val()) check("ptr", 32'(next_empty_ptr_o), 32'(q[0].addr));
    check("cnt", 32'(empty_cnt_o), 32'(model_cnt()));
    check("init_done", 32'(init_done_o), 32'(m_run));
    check("push_err", 32'(push_err_o), 32'(m_err));
  endtask

  // One clock: called at a negedge, drives inputs, steps the model at the
  // posedge and compares at the following negedge.
  task automatic cycle(input bit en, input logic [AW-1:0] addr, input bit ack);
    add_empty_ptr_en_i      = en;
    add_empty_ptr_i         = addr;
    next_empty_ptr_rd_ack_i = ack;
    @(posedge clk_i);
    model_step(en, addr, ack);
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic rand_cycles(input int n, input int p_en, input int p_ack);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 99) < p_en, AW'($urandom), $urandom_range(0, 99) < p_ack);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit hit;
    rst_n_i                 = 1'b0;
    add_empty_ptr_i         = '0;
    add_empty_ptr_en_i      = 1'b0;
    next_empty_ptr_rd_ack_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_outputs();
    check("rst_ptr", 32'(next_empty_ptr_o), 32'd0);
    rst_n_i = 1'b1;

    // Init sweep with a push dropped in the middle of it, then head appears.
    for (int i = 0; i < DEPTH + 2; i++) cycle(i == 3, 3'd6, 1'b0);
    repeat (2) cycle(1'b0, 3'd0, 1'b0);

    // Full: push without a pop is dropped; with a concurrent pop it is taken.
    cycle(1'b1, 3'd3, 1'b0);
    cycle(1'b1, 3'd3, 1'b1);

    // Drain back-to-back (1..7 then 3), plus acks while empty.
    for (int i = 0; i < DEPTH + 3; i++) cycle(1'b0, 3'd0, 1'b1);

    // Push into empty storage.
    cycle(1'b1, 3'd5, 1'b0);
    repeat (3) cycle(1'b0, 3'd0, 1'b0);

    // Push while the last entry is being popped.
    cycle(1'b1, 3'd7, 1'b1);
    repeat (3) cycle(1'b0, 3'd0, 1'b0);

    // Randomized traffic biased toward full, toward empty, then balanced.
    rand_cycles(150, 75, 25);
    rand_cycles(150, 25, 75);
    rand_cycles(200, 50, 50);

    // Steer to cnt=4 with a valid head, then reset mid-run.
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      if (model_cnt() == 4 && model_val()) hit = 1'b1;
      else cycle(model_cnt() < 4, AW'($urandom), model_cnt() > 4);
    end
    check("reach_cnt4_val", 32'(hit), 32'd1);

    #2 rst_n_i = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_ptr", 32'(next_empty_ptr_o), 32'd0);
    add_empty_ptr_en_i      = 1'b0;
    next_empty_ptr_rd_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    // Full init sweep repeats, then more random traffic.
    for (int i = 0; i < DEPTH + 4; i++) cycle(1'b0, 3'd0, 1'b0);
    rand_cycles(200, 50, 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ll_empty_ptr_storage
